// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO controller: the wrap-increment used by
// both pointers and the registered status bundle.
package fifo_pkg;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_full;
    } fifo_status_t;

    // Explicit wrap so depths that are not a power of two still cycle correctly.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping address counter over 0..D-1 with increment enable and synchronous
// reset; one instance each for the write and read pointers.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int D  = 4,
    parameter int DW = $clog2(D)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [DW-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= DW'(next_ptr(32'(ptr), D));
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller driving a two-port RAM (registered write,
// combinational read). Define FIFO_CTRL_ERR_EN to add sticky ovf/udf flags.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int D      = 4,
    parameter int AF_LVL = D - 1,
    localparam int DW    = $clog2(D),
    localparam int CW    = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
`ifdef FIFO_CTRL_ERR_EN
    input  logic          err_clr,
    output logic          ovf,
    output logic          udf,
`endif
    output logic          we,
    output logic [DW-1:0] wraddr,
    output logic [DW-1:0] rdaddr,
    output logic          empty,
    output logic          full,
    output logic          almost_full,
    output logic [CW-1:0] count
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] next_count;
    fifo_status_t  status;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is only safe when a pop frees the slot in the same cycle.
    assign do_push = push & (~status.full | pop);
    assign do_pop  = pop & ~status.empty;
    assign we      = do_push & ~rst;

    fifo_ptr #(.D(D), .DW(DW)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (do_push),
        .ptr (wraddr)
    );

    fifo_ptr #(.D(D), .DW(DW)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (do_pop),
        .ptr (rdaddr)
    );

    always_comb begin
        next_count = count_q;
        if (do_push & ~do_pop) begin
            next_count = count_q + CW'(1);
        end else if (do_pop & ~do_push) begin
            next_count = count_q - CW'(1);
        end
    end

    // Flags are registered from the next count so they line up with count itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q            <= '0;
            status.empty       <= 1'b1;
            status.full        <= 1'b0;
            status.almost_full <= 1'b0;
        end else begin
            count_q            <= next_count;
            status.empty       <= (next_count == '0);
            status.full        <= (next_count == CW'(D));
            status.almost_full <= (next_count >= CW'(AF_LVL));
        end
    end

    assign count       = count_q;
    assign empty       = status.empty;
    assign full        = status.full;
    assign almost_full = status.almost_full;

`ifdef FIFO_CTRL_ERR_EN
    logic ovf_q;
    logic udf_q;

    // A new error in the same cycle as err_clr must not be lost, so set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (push & status.full & ~pop) begin
                ovf_q <= 1'b1;
            end else if (err_clr) begin
                ovf_q <= 1'b0;
            end
            if (pop & status.empty) begin
                udf_q <= 1'b1;
            end else if (err_clr) begin
                udf_q <= 1'b0;
            end
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`endif

endmodule
